// File: rtl/ifetch_imem_bridge.sv
// ifetch_imem_bridge
//   Fetch-side slave: each accepted fetch request becomes a one-cycle-latency
//   read of a synchronous single-port instruction SRAM; the returned word is
//   queued in a small in-order FIFO and handed back under valid/ready.
//   Admission is occupancy based (queued entries + reads in flight), so every
//   read issued to the SRAM already owns a FIFO slot.
//
// Ports (the ifetch_if_t channel is flattened to ifetch_* signals):
//   clk, rst_n          clock, asynchronous active-low reset
//   ifetch_req_vld/rdy  fetch request handshake, ifetch_req_pc = byte address
//   ifetch_rsp_vld/rdy  response handshake, ifetch_rsp_ir = instruction
//   mem_en, mem_addr    SRAM read enable / word address (combinational)
//   mem_rdata           SRAM read data, valid the cycle after mem_en
//   misalign_err        sticky misaligned-fetch flag
//
// Optional feature: define IFETCH_ALIGN_CHK_EN to flag misaligned PCs. A
// misaligned fetch still reads the SRAM but returns a NOP, and sets
// misalign_err until reset. Undefined: PC[1:0] ignored, misalign_err = 0.

module ifetch_imem_bridge #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MEM_AW = 12,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifetch_req_vld,
    output logic              ifetch_req_rdy,
    input  logic [AW-1:0]     ifetch_req_pc,
    output logic              ifetch_rsp_vld,
    input  logic              ifetch_rsp_rdy,
    output logic [DW-1:0]     ifetch_rsp_ir,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic              misalign_err
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_pend_q, rd_pend_d;
    logic [DW-1:0]    buf_q [DEPTH];
    logic [DW-1:0]    buf_d [DEPTH];

    logic             req_hsk, rsp_hsk;
    logic [DW-1:0]    wr_data;

    // PC bits outside the word index are intentionally dropped (address wrap).
    logic unused_pc;
    assign unused_pc = ^{ifetch_req_pc[AW-1:MEM_AW+2], ifetch_req_pc[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // req_rdy depends on registered occupancy only: no path from rsp_rdy or
    // req_vld, so no combinational loop with the fetch unit.
    assign ifetch_req_rdy = (occ_q < DEPTH_C);
    assign req_hsk        = ifetch_req_vld & ifetch_req_rdy;
    assign rsp_hsk        = ifetch_rsp_vld & ifetch_rsp_rdy;

    assign mem_en   = req_hsk;
    assign mem_addr = ifetch_req_pc[MEM_AW+1:2];

    assign ifetch_rsp_vld = (cnt_q != '0);
    assign ifetch_rsp_ir  = buf_q[rd_ptr_q];

`ifdef IFETCH_ALIGN_CHK_EN
    logic mis_pend_q, mis_pend_d;
    logic misalign_err_q, misalign_err_d;

    // The per-entry misalign flag is folded into the stored word: the NOP is
    // substituted on the way in, keeping the output straight off storage.
    assign wr_data      = mis_pend_q ? DW'(32'h0000_0013) : mem_rdata;
    assign misalign_err = misalign_err_q;

    always_comb begin
        mis_pend_d     = req_hsk & (|ifetch_req_pc[1:0]);
        misalign_err_d = misalign_err_q | mis_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pend_q     <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            mis_pend_q     <= mis_pend_d;
            misalign_err_q <= misalign_err_d;
        end
    end
`else
    assign wr_data      = mem_rdata;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        occ_d = occ_q;
        case ({req_hsk, rsp_hsk})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // rd_pend_q marks that mem_rdata carries the word issued last cycle.
        rd_pend_d = req_hsk;

        cnt_d = cnt_q;
        case ({rd_pend_q, rsp_hsk})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        wr_ptr_d = rd_pend_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rsp_hsk   ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        buf_d = buf_q;
        if (rd_pend_q) buf_d[wr_ptr_q] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            buf_q     <= buf_d;
        end
    end

    // Admission makes these unreachable; they catch a broken occupancy count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_occ_bound: assert (occ_q <= DEPTH_C);
            a_fifo_ovf:  assert (!(rd_pend_q && cnt_q == DEPTH_C));
        end
    end

endmodule

// File: tb/tb_ifetch_imem_bridge.sv
module tb_ifetch_imem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [31:0] req_pc = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_ir;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        misalign_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifetch_imem_bridge #(.AW(32), .DW(32), .MEM_AW(12), .DEPTH(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifetch_req_vld (req_vld),
        .ifetch_req_rdy (req_rdy),
        .ifetch_req_pc  (req_pc),
        .ifetch_rsp_vld (rsp_vld),
        .ifetch_rsp_rdy (rsp_rdy),
        .ifetch_rsp_ir  (rsp_ir),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .misalign_err   (misalign_err)
    );

    // SRAM: word i holds 0x1000_0000+i, except word 0 = 0x0000_0093.
    logic [31:0] sram [4096];
    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = 32'h1000_0000 + i;
        sram[0] = 32'h0000_0093;
    end
    always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        rdy;
        logic        e_req_rdy;
        logic        e_mem_en;
        logic [11:0] e_addr;
        logic        e_rsp_vld;
        logic [31:0] e_ir;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, settle, then check.
    task automatic step(input logic v, input logic [31:0] pc, input logic r);
        @(negedge clk);
        req_vld = v;
        req_pc  = pc;
        rsp_rdy = r;
        #1;
    endtask

    initial begin
        // Streaming table: 16 fetches of pc=4k, then two drain cycles.
        for (int k = 0; k < 18; k++) begin
            vecs[k].vld       = (k < 16);
            vecs[k].pc        = (k < 16) ? 32'(4 * k) : 32'h0;
            vecs[k].rdy       = 1'b1;
            vecs[k].e_req_rdy = 1'b1;
            vecs[k].e_mem_en  = (k < 16);
            vecs[k].e_addr    = (k < 16) ? 12'(k) : 12'h0;
            vecs[k].e_rsp_vld = (k >= 2);
            if (k < 2)       vecs[k].e_ir = 32'h0;
            else if (k == 2) vecs[k].e_ir = 32'h0000_0093;
            else             vecs[k].e_ir = 32'h1000_0000 + 32'(k - 2);
        end

        // Reset state
        #1;
        chk("rst req_rdy", 32'(req_rdy), 32'h1);
        chk("rst rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst rsp_ir", rsp_ir, 32'h0);
        chk("rst misalign", 32'(misalign_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset release + streaming
        for (int k = 0; k < 18; k++) begin
            step(vecs[k].vld, vecs[k].pc, vecs[k].rdy);
            chk($sformatf("stream%0d req_rdy", k), 32'(req_rdy), 32'(vecs[k].e_req_rdy));
            chk($sformatf("stream%0d mem_en", k), 32'(mem_en), 32'(vecs[k].e_mem_en));
            chk($sformatf("stream%0d mem_addr", k), 32'(mem_addr), 32'(vecs[k].e_addr));
            chk($sformatf("stream%0d rsp_vld", k), 32'(rsp_vld), 32'(vecs[k].e_rsp_vld));
            chk($sformatf("stream%0d rsp_ir", k), rsp_ir, vecs[k].e_ir);
            chk($sformatf("stream%0d misalign", k), 32'(misalign_err), 32'h0);
        end

        // Backpressure: three accepted, then stall with stable output
        step(1'b1, 32'h100, 1'b0);
        chk("bp0 req_rdy", 32'(req_rdy), 32'h1);
        step(1'b1, 32'h104, 1'b0);
        chk("bp1 req_rdy", 32'(req_rdy), 32'h1);
        chk("bp1 rsp_vld", 32'(rsp_vld), 32'h0);
        step(1'b1, 32'h108, 1'b0);
        chk("bp2 req_rdy", 32'(req_rdy), 32'h1);
        chk("bp2 rsp_ir", rsp_ir, 32'h1000_0040);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h10C, 1'b0);
            chk("bp stall req_rdy", 32'(req_rdy), 32'h0);
            chk("bp stall mem_en", 32'(mem_en), 32'h0);
            chk("bp stall rsp_vld", 32'(rsp_vld), 32'h1);
            chk("bp stall rsp_ir", rsp_ir, 32'h1000_0040);
        end
        step(1'b1, 32'h10C, 1'b1);
        chk("bpC req_rdy", 32'(req_rdy), 32'h0);
        chk("bpC rsp_ir", rsp_ir, 32'h1000_0040);
        step(1'b1, 32'h10C, 1'b1);
        chk("bpC+1 req_rdy", 32'(req_rdy), 32'h1);
        chk("bpC+1 mem_en", 32'(mem_en), 32'h1);
        chk("bpC+1 rsp_ir", rsp_ir, 32'h1000_0041);
        step(1'b0, 32'h0, 1'b1);
        chk("bpC+2 rsp_ir", rsp_ir, 32'h1000_0042);
        step(1'b0, 32'h0, 1'b1);
        chk("bpC+3 rsp_vld", 32'(rsp_vld), 32'h1);
        chk("bpC+3 rsp_ir", rsp_ir, 32'h1000_0043);
        step(1'b0, 32'h0, 1'b1);
        chk("bpC+4 rsp_vld", 32'(rsp_vld), 32'h0);

        // Address wrap modulo SRAM size
        step(1'b1, 32'h0000_4008, 1'b1);
        chk("wrap mem_en", 32'(mem_en), 32'h1);
        chk("wrap mem_addr", 32'(mem_addr), 32'h002);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap rsp_vld", 32'(rsp_vld), 32'h1);
        chk("wrap rsp_ir", rsp_ir, 32'h1000_0002);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap drain", 32'(rsp_vld), 32'h0);

        // Misaligned fetch
`ifdef IFETCH_ALIGN_CHK_EN
        step(1'b1, 32'h6, 1'b1);
        chk("mis misalign pre", 32'(misalign_err), 32'h0);
        chk("mis mem_addr", 32'(mem_addr), 32'h1);
        step(1'b1, 32'h8, 1'b1);
        chk("mis misalign set", 32'(misalign_err), 32'h1);
        step(1'b0, 32'h0, 1'b1);
        chk("mis rsp_ir nop", rsp_ir, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b1);
        chk("mis aligned rsp_ir", rsp_ir, 32'h1000_0002);
        chk("mis sticky", 32'(misalign_err), 32'h1);
        step(1'b0, 32'h0, 1'b1);
        chk("mis drain", 32'(rsp_vld), 32'h0);
`else
        step(1'b1, 32'h6, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("mis ignored rsp_ir", rsp_ir, 32'h1000_0001);
        chk("mis tied", 32'(misalign_err), 32'h0);
        step(1'b0, 32'h0, 1'b1);
`endif

        // Reset with 2 queued + 1 in flight
        step(1'b1, 32'h20, 1'b0);
        step(1'b1, 32'h24, 1'b0);
        step(1'b1, 32'h28, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("prerst rsp_vld", 32'(rsp_vld), 32'h1);
        chk("prerst req_rdy", 32'(req_rdy), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_vld", 32'(rsp_vld), 32'h0);
        chk("midrst req_rdy", 32'(req_rdy), 32'h1);
        chk("midrst misalign", 32'(misalign_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h30, 1'b1);
        chk("postrst req_rdy", 32'(req_rdy), 32'h1);
        step(1'b0, 32'h0, 1'b1);
        chk("postrst no stale", 32'(rsp_vld), 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("postrst rsp_vld", 32'(rsp_vld), 32'h1);
        chk("postrst rsp_ir", rsp_ir, 32'h1000_000C);
        step(1'b0, 32'h0, 1'b1);
        chk("postrst drain", 32'(rsp_vld), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_imem_bridge.md
# ifetch_imem_bridge

Instruction-fetch slave that sits directly downstream of the fetch unit on the `ifetch_if_t` channel. It turns each accepted fetch request into a read of a synchronous single-port instruction SRAM with one-cycle read latency. Returned words go into a small in-order response FIFO and are presented back as `rsp_ir` under valid/ready. Occupancy-based admission guarantees that a read issued to the SRAM always has a FIFO slot waiting for it.

## Interface
- `AW`, default 32: fetch address width.
- `DW`, default 32: instruction and SRAM data width.
- `MEM_AW`, default 12: SRAM word-address width (4096 words).
- `DEPTH`, default 3, minimum 2: response FIFO entries.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ifetch.req_vld`  in  1  fetch request valid.
- `ifetch.req_rdy`  out  1  fetch request ready.
- `ifetch.req_pc`  in  AW  fetch byte address.
- `ifetch.rsp_vld`  out  1  instruction response valid.
- `ifetch.rsp_rdy`  in  1  response accepted by the fetch unit.
- `ifetch.rsp_ir`  out  DW  fetched instruction.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  MEM_AW  SRAM word address.
- `mem_rdata`  in  DW  SRAM read data, valid the cycle after `mem_en`.
- `misalign_err`  out  1  sticky misaligned-fetch flag (see Configuration).

## Operation
- Request handshake: `req_hsk = req_vld & req_rdy`. Response handshake: `rsp_hsk = rsp_vld & rsp_rdy`.
- `occ` is an unsigned counter of width `$clog2(DEPTH+1)`. It equals the FIFO entries held plus the reads in flight.
- Per cycle: `occ` increments on `req_hsk` and decrements on `rsp_hsk`. If both occur, `occ` is unchanged.
- `req_rdy = (occ < DEPTH)`. It is a registered-state function only and never depends on `rsp_rdy` or `req_vld`, so no combinational loop can form with the fetch unit.
- SRAM issue is combinational:
  - `mem_en = req_hsk`.
  - `mem_addr = req_pc[MEM_AW+1:2]`.
  - PC bits above `MEM_AW+1` are ignored, so addresses wrap modulo the SRAM size.
- In-flight tracking: a 1-bit register `rd_pend <= req_hsk` marks that `mem_rdata` is valid this cycle.
- When `rd_pend` is 1, `mem_rdata` is written into the FIFO at the write pointer.
- FIFO structure:
  - Circular buffer of `DEPTH` x `DW`.
  - Write and read pointers wrap from `DEPTH-1` to 0.
  - Entry count `cnt`.
- `rsp_vld = (cnt != 0)`. `rsp_ir` is the entry at the read pointer, driven directly from storage with no logic after the flop.
- Ordering: responses are returned strictly in request order, with no reordering or dropping.
- Overflow is structurally impossible: `occ <= DEPTH` at all times. A simulation assertion is required on `occ > DEPTH` and on a FIFO write while `cnt == DEPTH`.
- Simultaneous FIFO write and pop while `cnt == 0` is not possible, because data lands one cycle before it becomes visible. Write-while-pop at any `cnt >= 1` leaves `cnt` unchanged.
- Mid-operation reset clears `occ`, `cnt`, both pointers, `rd_pend` and `misalign_err`. Any read in flight is discarded and FIFO contents are don't-care.

## Timing
- Reset values:
  - `req_rdy = 1`.
  - `rsp_vld = 0`.
  - `mem_en = 0` (because `req_vld` gates it).
  - `rsp_ir = 0` (storage reset to 0).
  - `misalign_err = 0`.
- Latency: request accepted in cycle T, SRAM data in T+1, `rsp_vld` high in T+2. The minimum request-to-response latency is 2 cycles.
- Throughput:
  - With `DEPTH >= 3` and `rsp_rdy` held at 1: one request per cycle, `req_rdy` never drops.
  - With `DEPTH = 2`: at most 2 requests per 3 cycles.
- Backpressure: with `rsp_rdy = 0`, `req_rdy` falls the cycle after the `DEPTH`th outstanding acceptance.
  - A `rsp_hsk` in cycle C raises `req_rdy` in cycle C+1, not in C.
- `rsp_vld` must not drop and `rsp_ir` must not change while `rsp_vld & ~rsp_rdy`.

## Configuration
- Macro `IFETCH_ALIGN_CHK_EN`, defined:
  - A 1-bit flag `mis = |req_pc[1:0]` is captured alongside `rd_pend` and stored per FIFO entry.
  - An entry with `mis = 1` returns `rsp_ir = 32'h0000_0013` (NOP) instead of the SRAM data. The SRAM read is still issued.
  - `misalign_err` is set on the `req_hsk` of a misaligned PC and stays set until reset.
- Macro undefined:
  - `req_pc[1:0]` is ignored and no flag storage exists.
  - `misalign_err` is tied to 0.

## Test plan
- Reset release with SRAM word 0 = `32'h0000_0093`, `req_vld = 1`, `req_pc = 0`, `rsp_rdy = 1`: `req_rdy = 1` at cycle 0, `rsp_vld` and `rsp_ir = 32'h0000_0093` at cycle 2.
- Streaming `req_pc` = 0, 4, 8, … for 16 cycles with `rsp_rdy = 1` and `DEPTH = 3`: `req_rdy` stays 1 and the 16 responses return in order, one per cycle.
- Backpressure with `rsp_rdy = 0` and `req_vld = 1`: exactly 3 requests are accepted, then `req_rdy = 0` and `rsp_ir` stays stable. Raising `rsp_rdy` in cycle C gives `req_rdy = 1` in C+1, and order is preserved.
- Address wrap with `req_pc = 32'h0000_4008` and `MEM_AW = 12`: `mem_addr = 12'h002`.
- Macro `IFETCH_ALIGN_CHK_EN` defined, `req_pc = 32'h0000_0006`: `rsp_ir = 32'h0000_0013`, and `misalign_err = 1` from the next cycle until reset. The following aligned fetch returns SRAM data.
- Reset asserted with 2 responses queued and 1 read in flight: `rsp_vld = 0` and `req_rdy = 1` immediately. After reset release, the first new request returns its own data only, with no stale entry.
